// File: rtl/controller_module_if.sv
// Command/state bundle between the transaction front end and the sequencing
// controller. The master drives the three stage commands and observes the
// registered state code; the controller is the slave.
interface controller_module_if;
    logic [1:0] MS;
    logic [1:0] CS;
    logic [1:0] DS;
    logic [1:0] state;

    modport master (output MS, output CS, output DS, input state);
    modport slave  (input MS, input CS, input DS, output state);
endinterface

// File: rtl/controller_module.sv
// Four-state sequencing controller: IDLE -> COLLECT -> SELECT -> DISPENSE.
// Moore machine whose output is the state register itself. DISPENSE dwells
// for a fixed number of cycles using a down-counter, and can only be left
// early through a dispense cancel.
module controller_module #(
    parameter int DISPENSE_CYCLES = 3
) (
    input  logic           clk,
    input  logic           rst,
    controller_module_if.slave bus
);

    localparam int CW = $clog2(DISPENSE_CYCLES) + 1;

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t LOAD_VAL = cnt_t'(DISPENSE_CYCLES - 1);
    localparam cnt_t ONE      = cnt_t'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        COLLECT  = 2'b01,
        SELECT   = 2'b10,
        DISPENSE = 2'b11
    } state_t;

    // Command encodings shared by the three inputs; code 11 matches nothing
    // below and therefore behaves as "none".
    localparam logic [1:0] CMD_ADVANCE = 2'b01;
    localparam logic [1:0] CMD_ABORT   = 2'b10;

    state_t state_q;
    state_t next_state;
    cnt_t   dcnt;
    cnt_t   next_dcnt;

    // State and dwell counter registers; reset forces IDLE with no residual count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            dcnt    <= '0;
        end else begin
            state_q <= next_state;
            dcnt    <= next_dcnt;
        end
    end

    // Next-state rules in priority order (abort/back first, MS over CS over DS).
    always_comb begin
        next_state = state_q;
        next_dcnt  = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.MS == CMD_ADVANCE) begin
                    next_state = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.MS == CMD_ABORT) begin
                    next_state = IDLE;
                end else if (bus.CS == CMD_ADVANCE) begin
                    next_state = SELECT;
                end
            end
            SELECT: begin
                if (bus.MS == CMD_ABORT) begin
                    next_state = IDLE;
                end else if (bus.CS == CMD_ABORT) begin
                    next_state = COLLECT;
                end else if (bus.DS == CMD_ADVANCE) begin
                    next_state = DISPENSE;
                    next_dcnt  = LOAD_VAL;
                end
            end
            DISPENSE: begin
                if (bus.DS == CMD_ABORT) begin
                    next_state = IDLE;
                end else if (dcnt == '0) begin
                    next_state = IDLE;
                end else begin
                    next_dcnt = dcnt - ONE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign bus.state = state_q;

endmodule

// File: tb/tb_controller_module.sv
// Directed bench for controller_module: reset behaviour, nominal flow,
// abort/back priority, dispense dwell/cancel/immunity, reserved codes,
// asynchronous reset mid-dispense, and a single-cycle dispense variant.
module tb_controller_module;

    logic clk;
    logic rst;

    int checkCount;
    int errorCount;

    controller_module_if bus ();
    controller_module_if busOne ();

    controller_module #(.DISPENSE_CYCLES(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    controller_module #(.DISPENSE_CYCLES(1)) dutOne (
        .clk (clk),
        .rst (rst),
        .bus (busOne.slave)
    );

    // Free-running clock, period 20.
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // Hard time bound so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation exceeded time bound");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [1:0] observed, input logic [1:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] ms, input logic [1:0] cs, input logic [1:0] ds);
        bus.MS = ms;
        bus.CS = cs;
        bus.DS = ds;
    endtask

    task automatic applyStimulusOne(input logic [1:0] ms, input logic [1:0] cs, input logic [1:0] ds);
        busOne.MS = ms;
        busOne.CS = cs;
        busOne.DS = ds;
    endtask

    // Advance past one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a command, take one edge, check the resulting state.
    task automatic stepCheck(input string tag, input logic [1:0] ms, input logic [1:0] cs,
                             input logic [1:0] ds, input logic [1:0] expected);
        applyStimulus(ms, cs, ds);
        tick();
        checkOutput(tag, bus.state, expected);
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        rst = 1'b0;
        applyStimulus(2'b01, 2'b01, 2'b01);
        applyStimulusOne(2'b00, 2'b00, 2'b00);
        #1;
        checkOutput("reset_initial", bus.state, 2'b00);
        checkOutput("reset_initial_n1", busOne.state, 2'b00);

        // Inputs toggling while reset held
        tick();
        checkOutput("reset_hold_a", bus.state, 2'b00);
        applyStimulus(2'b00, 2'b00, 2'b00);
        tick();
        checkOutput("reset_hold_b", bus.state, 2'b00);
        applyStimulus(2'b01, 2'b01, 2'b01);
        tick();
        checkOutput("reset_hold_c", bus.state, 2'b00);

        // Release reset; held MS=01 moves to COLLECT on next edge
        applyStimulus(2'b01, 2'b00, 2'b00);
        rst = 1'b1;
        tick();
        checkOutput("release_collect", bus.state, 2'b01);

        // Nominal flow
        stepCheck("to_select",   2'b01, 2'b01, 2'b00, 2'b10);
        stepCheck("disp_c1",     2'b01, 2'b00, 2'b01, 2'b11);
        stepCheck("disp_c2",     2'b01, 2'b00, 2'b00, 2'b11);
        stepCheck("disp_c3",     2'b01, 2'b00, 2'b00, 2'b11);
        stepCheck("disp_done",   2'b01, 2'b00, 2'b00, 2'b00);
        stepCheck("reenter_col", 2'b01, 2'b00, 2'b00, 2'b01);

        // Abort beats advance in COLLECT
        stepCheck("col_abort_wins", 2'b10, 2'b01, 2'b00, 2'b00);

        // Abort from SELECT
        stepCheck("ab_collect", 2'b01, 2'b00, 2'b00, 2'b01);
        stepCheck("ab_select",  2'b00, 2'b01, 2'b00, 2'b10);
        stepCheck("sel_abort",  2'b10, 2'b00, 2'b00, 2'b00);

        // Back from SELECT with MS=01 held
        stepCheck("bk_collect", 2'b01, 2'b00, 2'b00, 2'b01);
        stepCheck("bk_select",  2'b01, 2'b01, 2'b00, 2'b10);
        stepCheck("sel_back",   2'b01, 2'b10, 2'b00, 2'b01);

        // Back beats dispense start in SELECT
        stepCheck("pr_select",      2'b00, 2'b01, 2'b00, 2'b10);
        stepCheck("back_beats_ds",  2'b00, 2'b10, 2'b01, 2'b01);

        // Dispense immunity to MS/CS, then cancel
        stepCheck("im_select",   2'b00, 2'b01, 2'b00, 2'b10);
        stepCheck("im_disp",     2'b00, 2'b00, 2'b01, 2'b11);
        stepCheck("disp_immune", 2'b10, 2'b10, 2'b00, 2'b11);
        stepCheck("disp_cancel", 2'b10, 2'b10, 2'b10, 2'b00);

        // Reserved codes are no-ops in IDLE, COLLECT and SELECT
        for (int i = 0; i < 5; i++) begin
            stepCheck($sformatf("rsv_idle_%0d", i), 2'b11, 2'b11, 2'b11, 2'b00);
        end
        stepCheck("rsv_to_collect", 2'b01, 2'b00, 2'b00, 2'b01);
        for (int i = 0; i < 5; i++) begin
            stepCheck($sformatf("rsv_collect_%0d", i), 2'b11, 2'b11, 2'b11, 2'b01);
        end
        stepCheck("rsv_to_select", 2'b00, 2'b01, 2'b00, 2'b10);
        for (int i = 0; i < 5; i++) begin
            stepCheck($sformatf("rsv_select_%0d", i), 2'b11, 2'b11, 2'b11, 2'b10);
        end

        // Asynchronous reset in the second cycle of DISPENSE
        stepCheck("ar_idle",    2'b10, 2'b00, 2'b00, 2'b00);
        stepCheck("ar_collect", 2'b01, 2'b00, 2'b00, 2'b01);
        stepCheck("ar_select",  2'b00, 2'b01, 2'b00, 2'b10);
        stepCheck("ar_disp1",   2'b00, 2'b00, 2'b01, 2'b11);
        stepCheck("ar_disp2",   2'b00, 2'b00, 2'b00, 2'b11);
        #4;
        rst = 1'b0;
        #1;
        checkOutput("async_reset", bus.state, 2'b00);
        tick();
        checkOutput("async_reset_hold", bus.state, 2'b00);
        rst = 1'b1;
        stepCheck("restart_idle",    2'b00, 2'b00, 2'b00, 2'b00);
        stepCheck("restart_collect", 2'b01, 2'b00, 2'b00, 2'b01);
        stepCheck("restart_select",  2'b00, 2'b01, 2'b00, 2'b10);
        stepCheck("restart_disp1",   2'b00, 2'b00, 2'b01, 2'b11);
        stepCheck("restart_disp2",   2'b00, 2'b00, 2'b00, 2'b11);
        stepCheck("restart_disp3",   2'b00, 2'b00, 2'b00, 2'b11);
        stepCheck("restart_done",    2'b00, 2'b00, 2'b00, 2'b00);

        // Single-cycle dispense variant
        checkOutput("n1_idle", busOne.state, 2'b00);
        applyStimulusOne(2'b01, 2'b00, 2'b00);
        tick();
        checkOutput("n1_collect", busOne.state, 2'b01);
        applyStimulusOne(2'b00, 2'b01, 2'b00);
        tick();
        checkOutput("n1_select", busOne.state, 2'b10);
        applyStimulusOne(2'b00, 2'b00, 2'b01);
        tick();
        checkOutput("n1_disp", busOne.state, 2'b11);
        tick();
        checkOutput("n1_done", busOne.state, 2'b00);
        tick();
        checkOutput("n1_stay_idle", busOne.state, 2'b00);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/controller_module.md
# controller_module

Four-state sequencing controller for the transaction front end. It steps through IDLE, COLLECT, SELECT and DISPENSE under three 2-bit command inputs: MS (money stage), CS (choice stage) and DS (dispense stage). It drives the current state code to downstream datapath and display logic. DISPENSE lasts a fixed number of cycles, after which the block returns to IDLE on its own.

## Interface
- DISPENSE_CYCLES, default 3: number of clock cycles spent in DISPENSE; legal range 1..255.
- clk  input  1  system clock; all state changes occur on the rising edge.
- rst  input  1  reset, asynchronous and active-low.
- MS  input  2  money command: 00 none, 01 advance, 10 abort, 11 reserved (treated as 00).
- CS  input  2  choice command: 00 none, 01 advance, 10 back, 11 reserved (treated as 00).
- DS  input  2  dispense command: 00 none, 01 start, 10 cancel, 11 reserved (treated as 00).
- state  output  2  registered current state: 00 IDLE, 01 COLLECT, 10 SELECT, 11 DISPENSE.

## Operation
- Moore FSM. `state` is the state register itself, with no combinational path from inputs to output.
- Commands are level-sensitive. A command held high acts on every edge where its state condition applies.
- Internal down-counter `dcnt`, width ceil(log2(DISPENSE_CYCLES))+1 bits; used only in DISPENSE.
- Transitions, evaluated per rising edge; the first matching rule wins:
  - IDLE: MS=01 → COLLECT; otherwise stay.
  - COLLECT: MS=10 → IDLE; CS=01 → SELECT; otherwise stay.
  - SELECT: MS=10 → IDLE; CS=10 → COLLECT; DS=01 → DISPENSE, with dcnt loaded to DISPENSE_CYCLES-1; otherwise stay.
  - DISPENSE: DS=10 → IDLE; dcnt==0 → IDLE; otherwise stay, with dcnt decremented by 1.
- MS and CS are ignored in DISPENSE. A dispense in progress can only be cancelled via DS=10.
- Simultaneous commands resolve by the priority order above: abort/back beats advance, and MS outranks CS, which outranks DS.
- Reserved code 11 on any input is a no-op in every state.
- On return from DISPENSE to IDLE, a still-held MS=01 moves the block to COLLECT on the following edge (normal IDLE rule).
- dcnt is don't-care outside DISPENSE but is held at 0 in all other states.

## Timing
- While rst=0: state=00 and dcnt=0 immediately, independent of clk.
- rst deassertion is sampled only at rising edges of clk. The first transition can occur on the first rising edge after rst goes high.
- Latency: a command stable before rising edge N is reflected on `state` after edge N (1 cycle).
- DISPENSE dwell:
  - `state`=11 for exactly DISPENSE_CYCLES consecutive cycles, then 00, provided DS≠10 throughout.
  - With DISPENSE_CYCLES=1, DISPENSE lasts one cycle.
- DS=10 during DISPENSE gives state=00 after the next edge, regardless of dcnt.
- Reset mid-operation, including mid-DISPENSE, aborts immediately to IDLE. No residual count survives.
- Input codes change only between edges; the block contains no synchronisers.

## Test plan
- Reset: assert rst=0 with MS=CS=DS=01 toggling → state=00 throughout. Release rst → next edge gives 01.
- Nominal flow (DISPENSE_CYCLES=3), period 20, rst released at t=20:
  - MS=01 at 40 → state 01.
  - CS=01 at 60 → state 10.
  - DS=01 at 80 → state 11 for 3 cycles, then 00, then 01 (MS still 01).
- Abort and back:
  - In SELECT, MS=10 → 00.
  - In SELECT, CS=10 with MS=01 → 01.
  - In COLLECT, MS=10 and CS=01 together → 00 (abort wins).
- Dispense cancel and immunity:
  - In DISPENSE, MS=10 and CS=10 → state stays 11.
  - In DISPENSE, DS=10 → 00 after one edge.
- Reserved codes: MS=CS=DS=11 in each of IDLE, COLLECT and SELECT → state unchanged for 5 cycles.
- Async reset mid-DISPENSE: drop rst between edges in cycle 2 of DISPENSE → state=00 without a clock edge. After release, the sequence restarts from IDLE.
